// File: rtl/branch_ctrl_pkg.sv
// rtl/branch_ctrl_pkg.sv - shared types and constants for the branch redirect controller
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_e;

  localparam int XLEN_DEF = 32;

  // Only target bit 1 matters for 4-byte alignment; bit 0 is cleared on redirect.
  localparam logic [1:0] ALIGN_MASK = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter used for debug statistics
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && !(&q_q)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - redirects fetch on taken branches/jumps, kills wrong path, drains pipeline
module branch_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            br_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_pc,
  output logic            kill,
  output logic            busy,
  output logic            misalign_exc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = (DRAIN_CYCLES > 0) ? CW'(DRAIN_CYCLES - 1) : '0;
  localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(1);

  state_e          state_q, state_d;
  logic            redir_valid_q, redir_valid_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            kill_q, kill_d;
  logic            busy_q, busy_d;
  logic            misalign_q, misalign_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            xfer, misaligned, branch_inc, taken_inc;

  // A branch+jump combination resolves as a jump.
  assign xfer       = ex_valid & (ex_is_jump | (ex_is_branch & br_taken));
  assign misaligned = |(ex_target[1:0] & ALIGN_MASK);

  always_comb begin
    state_d       = state_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    kill_d        = 1'b0;
    busy_d        = busy_q;
    misalign_d    = 1'b0;
    cnt_d         = cnt_q;
    branch_inc    = 1'b0;
    taken_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        branch_inc = ex_valid & ex_is_branch;
        busy_d     = 1'b0;
        if (xfer) begin
          if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            state_d       = REDIRECT;
            redir_valid_d = 1'b1;
            redir_pc_d    = ex_target & PC_MASK;
            kill_d        = 1'b1;
            busy_d        = 1'b1;
            taken_inc     = 1'b1;
          end
        end
      end
      REDIRECT: begin
        if (redir_ready) begin
          redir_valid_d = 1'b0;
          if (DRAIN_CYCLES == 0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = DRAIN;
            cnt_d   = CNT_INIT;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d       = IDLE;
        redir_valid_d = 1'b0;
        busy_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      kill_q        <= 1'b0;
      busy_q        <= 1'b0;
      misalign_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      kill_q        <= kill_d;
      busy_q        <= busy_d;
      misalign_q    <= misalign_d;
      cnt_q         <= cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (branch_inc),
    .clr   (1'b0),
    .q     (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (taken_inc),
    .clr   (1'b0),
    .q     (taken_cnt)
  );

  assign redir_valid  = redir_valid_q;
  assign redir_pc     = redir_pc_q;
  assign kill         = kill_q;
  assign busy         = busy_q;
  assign misalign_exc = misalign_q;

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences control-flow changes in the RISC-V core under static not-taken prediction. It samples the resolved branch outcome from EX (the taken/not-taken bit from the branch-condition unit), decides whether fetch must be redirected, and issues a one-cycle pipeline kill. It then holds a valid/ready redirect request to the fetch unit and drains the pipeline for a fixed number of cycles before accepting the next control transfer. It also keeps saturating branch statistics for debug.

Parameters:
XLEN, 32, address width
DRAIN_CYCLES, 2, idle cycles after redirect handshake before re-arming (0 allowed)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX stage holds a live instruction
ex_is_branch  in  1  EX instruction is a conditional branch
ex_is_jump  in  1  EX instruction is JAL/JALR
br_taken  in  1  resolved branch condition from branch-condition unit
ex_target  in  XLEN  computed branch/jump target
redir_valid  out  1  redirect request to fetch
redir_ready  in  1  fetch accepts redirect
redir_pc  out  XLEN  redirect address, bit 0 forced to 0
kill  out  1  one-cycle flush of IF/ID/EX wrong-path contents
busy  out  1  controller not in IDLE; stalls issue into EX
misalign_exc  out  1  one-cycle pulse: taken target not 4-byte aligned
branch_cnt  out  CNT_W  conditional branches resolved (saturating)
taken_cnt  out  CNT_W  control transfers redirected (saturating)

Behaviour:
- Clock: single clock, clk. Reset: asynchronous, active-low rst_n. On reset assertion, all state clears immediately: state=IDLE, redir_valid=0, redir_pc=0, kill=0, busy=0, misalign_exc=0, both counters=0. Reset mid-redirect abandons the request; no handshake is completed.
- All outputs are registered.
- xfer = ex_valid & (ex_is_jump | (ex_is_branch & br_taken)), sampled only in IDLE.
- State IDLE:
  - xfer with target[1]==0: on the next edge, go to REDIRECT. Set redir_pc={ex_target[XLEN-1:1],1'b0}, redir_valid=1, kill=1 for exactly that cycle, busy=1.
  - xfer with target[1]==1: misalign_exc pulses for 1 cycle. No redirect, no kill, stay IDLE.
  - No xfer: outputs stay at idle values.
- State REDIRECT:
  - Hold redir_valid and redir_pc stable until the edge where redir_valid & redir_ready.
  - A ready already high in the first REDIRECT cycle completes the handshake in that cycle.
  - After the handshake, redir_valid drops on the next edge.
  - Next state is DRAIN with cnt=DRAIN_CYCLES-1, or IDLE if DRAIN_CYCLES==0.
- State DRAIN: busy=1. Decrement cnt each cycle. Go to IDLE on the edge where cnt==0. Latency from handshake to busy deassert is DRAIN_CYCLES cycles.
- Outside IDLE, ex_valid is ignored. ex_valid=1 while busy is a protocol violation; the bench flags it with an assertion.
- Statistics:
  - branch_cnt increments on ex_valid & ex_is_branch in IDLE, whether taken or not.
  - taken_cnt increments when IDLE→REDIRECT.
  - Both counters saturate at all-ones and do not wrap.
- ex_is_branch & ex_is_jump both high: treated as a jump (taken); branch_cnt still increments.
- Total redirect penalty with redir_ready tied high is 1 (REDIRECT) + DRAIN_CYCLES cycles of busy.

Decomposition:
- Shared package branch_ctrl_pkg:
  - state enum {IDLE, REDIRECT, DRAIN}
  - XLEN default
  - alignment-mask constant
- One natural sub-module: sat_counter (parameter W, inputs inc/clr, saturating). It is instantiated twice, for branch_cnt and taken_cnt.

Test Plan:
- Reset, then a not-taken branch (ex_is_branch=1, br_taken=0, target=0x100) → no kill, redir_valid=0, branch_cnt=1, taken_cnt=0.
- Taken branch to 0x0000_0040, redir_ready tied 1, DRAIN_CYCLES=2:
  - kill high exactly 1 cycle; redir_pc=0x40; redir_valid high 1 cycle.
  - busy high 3 cycles; taken_cnt=1.
- JAL to 0x0000_0080 with redir_ready held 0 for 4 cycles, then 1 → redir_valid and redir_pc=0x80 stable for all 5 cycles; exactly one handshake.
- Taken branch to 0x0000_0042 (target[1]=1) → misalign_exc 1-cycle pulse; no kill, no redirect, state stays IDLE.
- rst_n driven low during REDIRECT (redir_ready=0) → redir_valid, busy and kill drop asynchronously; counters read 0; a fresh taken branch afterwards redirects normally.
- CNT_W=4, 20 back-to-back not-taken branches → branch_cnt saturates at 0xF and holds.
